// File: rtl/maxpool_engine_if.sv
// Memory and control bus of the layer-1 max-pooling stage.
// The engine side is master; the shared result memory and controller are slave.
interface maxpool_engine_if #(
  parameter int DW = 20,
  parameter int AW = 12
);
  logic          start;
  logic          busy;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  modport master (
    input  start, cdata_rd,
    output busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );

  modport slave (
    output start, cdata_rd,
    input  busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );
endinterface

// File: rtl/maxpool_engine.sv
// 2x2 stride-2 max-pooling of the 64x64 layer-0 map into the 32x32 layer-1 map.
// Each output word takes four reads (RD0..RD3) followed by one write (WR).
module maxpool_engine #(
  parameter int DW    = 20,
  parameter int IMG_W = 64,
  parameter int AW    = 12
) (
  input  logic              clk,
  input  logic              reset,
  maxpool_engine_if.master  bus
);

  localparam int OW = IMG_W / 2;
  localparam int CW = $clog2(OW);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, WR} state_t;

  state_t                state_q;
  logic [CW-1:0]         row_q, col_q;
  logic signed [DW-1:0]  max_q;
  logic                  busy_q, crd_q, cwr_q;
  logic [AW-1:0]         caddrRd_q, caddrWr_q;
  logic [DW-1:0]         cdataWr_q;
  logic [2:0]            csel_q;

  logic [CW-1:0]         colNext_d, rowNext_d;
  logic                  lastWord_d;
  logic [AW-1:0]         base_d, nextBase_d, writeAddr_d;
  logic signed [DW-1:0]  rdData, maxUpd_d;

  // Top-left address of the window: (2r)*IMG_W + 2c
  function automatic logic [AW-1:0] baseAddr(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return (AW'(r) << (CW + 2)) | (AW'(c) << 1);
  endfunction

  assign rdData = bus.cdata_rd;

  always_comb begin
    colNext_d   = col_q + 1'b1;
    rowNext_d   = (col_q == CW'(OW - 1)) ? row_q + 1'b1 : row_q;
    lastWord_d  = (row_q == CW'(OW - 1)) && (col_q == CW'(OW - 1));
    base_d      = baseAddr(row_q, col_q);
    nextBase_d  = baseAddr(rowNext_d, colNext_d);
    writeAddr_d = AW'({row_q, col_q});
    maxUpd_d    = (rdData > max_q) ? rdData : max_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      max_q     <= '0;
      busy_q    <= 1'b0;
      crd_q     <= 1'b0;
      cwr_q     <= 1'b0;
      caddrRd_q <= '0;
      caddrWr_q <= '0;
      cdataWr_q <= '0;
      csel_q    <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= RD0;
            busy_q    <= 1'b1;
            crd_q     <= 1'b1;
            csel_q    <= 3'b001;
            row_q     <= '0;
            col_q     <= '0;
            caddrRd_q <= '0;
          end
        end
        RD0: begin
          max_q     <= rdData;
          caddrRd_q <= base_d + AW'(1);
          state_q   <= RD1;
        end
        RD1: begin
          max_q     <= maxUpd_d;
          caddrRd_q <= base_d + AW'(IMG_W);
          state_q   <= RD2;
        end
        RD2: begin
          max_q     <= maxUpd_d;
          caddrRd_q <= base_d + AW'(IMG_W + 1);
          state_q   <= RD3;
        end
        // Reads and writes share csel, so the strobe swap happens on one edge.
        RD3: begin
          max_q     <= maxUpd_d;
          crd_q     <= 1'b0;
          cwr_q     <= 1'b1;
          csel_q    <= 3'b011;
          caddrWr_q <= writeAddr_d;
          cdataWr_q <= maxUpd_d;
          state_q   <= WR;
        end
        WR: begin
          cwr_q <= 1'b0;
          col_q <= colNext_d;
          row_q <= rowNext_d;
          if (lastWord_d) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            csel_q  <= 3'b000;
          end else begin
            state_q   <= RD0;
            crd_q     <= 1'b1;
            csel_q    <= 3'b001;
            caddrRd_q <= nextBase_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          crd_q   <= 1'b0;
          cwr_q   <= 1'b0;
          csel_q  <= 3'b000;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.crd      = crd_q;
  assign bus.cwr      = cwr_q;
  assign bus.caddr_rd = caddrRd_q;
  assign bus.caddr_wr = caddrWr_q;
  assign bus.cdata_wr = cdataWr_q;
  assign bus.csel     = csel_q;

endmodule

// File: tb/tb_maxpool_engine.sv
// Directed bench for maxpool_engine: behavioural result memory, bus monitor and L1 checks.
module tb_maxpool_engine;

  localparam int DW = 20;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;

  maxpool_engine_if #(.DW(DW), .AW(AW)) bus ();

  maxpool_engine #(.DW(DW), .IMG_W(64), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] l0 [4096];
  logic [DW-1:0] l1 [1024];

  int checks = 0;
  int errors = 0;
  int busyCycles, readCnt, writeCnt, addrErr, selErr;

  // Layer-0 reads are combinational; layer-1 writes land on the edge ending the WR cycle
  assign bus.cdata_rd = l0[bus.caddr_rd];

  always @(posedge clk) begin
    if (bus.cwr && bus.csel == 3'b011) l1[bus.caddr_wr[9:0]] <= bus.cdata_wr;
  end

  function automatic logic [AW-1:0] expRdAddr(input int idx);
    int k, p, r, c;
    k = idx / 4; p = idx % 4; r = k / 32; c = k % 32;
    return AW'(r * 128 + c * 2 + (p % 2) + (p / 2) * 64);
  endfunction

  always @(negedge clk) begin
    if (bus.busy) busyCycles++;
    if (bus.crd && bus.cwr) selErr++;
    if (!bus.crd && !bus.cwr && bus.csel != 3'b000) selErr++;
    if (bus.crd) begin
      if (bus.csel != 3'b001) selErr++;
      if (bus.caddr_rd != expRdAddr(readCnt)) addrErr++;
      readCnt++;
    end
    if (bus.cwr) begin
      if (bus.csel != 3'b011) selErr++;
      if (bus.caddr_wr != AW'(writeCnt)) addrErr++;
      writeCnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // mode 0: ramp, 1: single corner maximum, 2: signed windows
  function automatic logic [DW-1:0] windowWord(input int mode, input int k, input int p, input int a);
    logic [DW-1:0] sgn [4];
    logic [DW-1:0] neg [4];
    sgn = '{20'hFFFFF, 20'h80000, 20'h00000, 20'hFFFF0};
    neg = '{20'hFFFFF, 20'h80000, 20'hFFFF0, 20'hC0000};
    case (mode)
      0:       return DW'(a);
      1:       return (p == k % 4) ? 20'h01000 : 20'h00010;
      default: return (k % 2 == 0) ? sgn[p] : neg[p];
    endcase
  endfunction

  function automatic logic [DW-1:0] expectL1(input int mode, input int k);
    int r, c;
    r = k / 32; c = k % 32;
    case (mode)
      0:       return DW'(2 * r * 64 + 2 * c + 65);
      1:       return 20'h01000;
      default: return (k % 2 == 0) ? 20'h00000 : 20'hFFFFF;
    endcase
  endfunction

  task automatic fillL0(input int mode);
    int base;
    for (int k = 0; k < 1024; k++) begin
      base = (k / 32) * 128 + (k % 32) * 2;
      for (int p = 0; p < 4; p++) begin
        l0[base + (p % 2) + (p / 2) * 64] = windowWord(mode, k, p, base + (p % 2) + (p / 2) * 64);
      end
    end
    for (int k = 0; k < 1024; k++) l1[k] = 20'h55555;
  endtask

  task automatic checkL1(input string tag, input int mode);
    int bad;
    bad = 0;
    for (int k = 0; k < 1024; k++) if (l1[k] !== expectL1(mode, k)) bad++;
    checkOutput({tag, "_l1bad"}, bad, 0);
    checkOutput({tag, "_l1first"}, l1[0], expectL1(mode, 0));
    checkOutput({tag, "_l1last"}, l1[1023], expectL1(mode, 1023));
  endtask

  // Starts a pass from the current (negedge) time and returns at the first IDLE negedge
  task automatic applyStimulus(input int holdCycles, input int repulseAt, input string tag);
    int n;
    busyCycles = 0; readCnt = 0; writeCnt = 0; addrErr = 0; selErr = 0;
    bus.start = 1'b1;
    n = 0;
    while (n < 6000) begin
      @(negedge clk);
      n++;
      if (n == holdCycles) bus.start = 1'b0;
      if (n == repulseAt) bus.start = 1'b1;
      if (n == repulseAt + 1) bus.start = 1'b0;
      if (!bus.busy) break;
    end
    bus.start = 1'b0;
    checkOutput({tag, "_timeout"}, (n >= 6000), 0);
    checkOutput({tag, "_busycycles"}, busyCycles, 5120);
    checkOutput({tag, "_reads"}, readCnt, 4096);
    checkOutput({tag, "_writes"}, writeCnt, 1024);
    checkOutput({tag, "_addrerr"}, addrErr, 0);
    checkOutput({tag, "_selerr"}, selErr, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    busyCycles = 0; readCnt = 0; writeCnt = 0; addrErr = 0; selErr = 0;
    fillL0(0);
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_crd", bus.crd, 0);
    checkOutput("rst_cwr", bus.cwr, 0);
    checkOutput("rst_csel", bus.csel, 0);
    checkOutput("rst_caddr_rd", bus.caddr_rd, 0);
    checkOutput("rst_cdata_wr", bus.cdata_wr, 0);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(1, -10, "ramp");
    checkL1("ramp", 0);

    // Held and re-pulsed start must not disturb the single pass
    @(negedge clk);
    fillL0(0);
    applyStimulus(10, 2000, "hold");
    checkL1("hold", 0);
    repeat (20) @(negedge clk);
    checkOutput("hold_noretrigger", bus.busy, 0);
    checkOutput("hold_noextra_reads", readCnt, 4096);

    @(negedge clk);
    fillL0(1);
    applyStimulus(1, -10, "corner");
    checkL1("corner", 1);

    @(negedge clk);
    fillL0(2);
    applyStimulus(1, -10, "signed");
    checkL1("signed", 2);
    checkOutput("signed_l1_1", l1[1], 20'hFFFFF);

    // Abort mid-operation, then a fresh pass from address 0
    @(negedge clk);
    fillL0(0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (1502) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_crd", bus.crd, 0);
    checkOutput("abort_cwr", bus.cwr, 0);
    checkOutput("abort_csel", bus.csel, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("abort_idle", bus.busy, 0);
    for (int k = 0; k < 1024; k++) l1[k] = 20'h55555;
    applyStimulus(1, -10, "restart");
    checkL1("restart", 0);

    // Back-to-back: second start in the first IDLE cycle
    @(negedge clk);
    fillL0(1);
    applyStimulus(1, -10, "b2b_first");
    checkL1("b2b_first", 1);
    for (int k = 0; k < 1024; k++) l1[k] = 20'h55555;
    applyStimulus(1, -10, "b2b_second");
    checkL1("b2b_second", 1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool_engine.md
Name: maxpool_engine

Overview:
- Layer-1 stage of the CONV datapath. Consumes the 64x64 layer-0 convolution map (csel 3'b001) from the shared result memory.
- Performs 2x2, stride-2 max-pooling and writes the 32x32 layer-1 map (csel 3'b011) back through the same memory port.
- Started by the convolution controller after its last layer-0 write. Holds busy until the last layer-1 write is done.

Parameters:
- DW, 20, data width of one memory word (signed, 4.16 fixed point)
- IMG_W, 64, input map width and height (power of two)
- AW, 12, memory address width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset
- start  input  1  one-cycle request to begin pooling; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until pooling ends
- crd  output  1  memory read strobe
- caddr_rd  output  AW  memory read address
- cdata_rd  input  DW  memory read data; valid at the rising edge that ends the cycle in which crd is high
- cwr  output  1  memory write strobe; the write happens at the rising edge ending the cycle
- caddr_wr  output  AW  memory write address
- cdata_wr  output  DW  memory write data
- csel  output  3  bank select: 3'b001 during reads, 3'b011 during writes, 3'b000 otherwise

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE.
  - busy, crd and cwr go to 0.
  - caddr_rd, caddr_wr, cdata_wr and csel go to 0.
  - Row and column counters and the max register are cleared.
  - Reset in the middle of an operation aborts it immediately. No further reads or writes occur. The partial layer-1 contents are left as written.
- States: IDLE, RD0, RD1, RD2, RD3, WR.
- IDLE:
  - start==1 moves to RD0.
  - busy=1 from that next cycle.
- Pooling window for output row r, column c (r, c in 0..IMG_W/2-1):
  - base = (2r)*IMG_W + 2c.
  - RD0 reads base, RD1 reads base+1, RD2 reads base+IMG_W, RD3 reads base+IMG_W+1.
  - In RDx: crd=1, cwr=0, csel=3'b001, caddr_rd set to that address.
- Max register:
  - At the end of RD0 it loads cdata_rd.
  - At the end of RD1, RD2 and RD3 it becomes the signed maximum of itself and cdata_rd.
  - Comparison is signed two's-complement over the full DW bits. The result is an exact copy of one input word, with no rounding or saturation.
- WR:
  - cwr=1, crd=0, csel=3'b011.
  - caddr_wr = r*(IMG_W/2)+c, zero-extended to AW.
  - cdata_wr = max register.
- After WR:
  - c increments. When c wraps from IMG_W/2-1 to 0, r increments.
  - If the word just written was (r,c) = (IMG_W/2-1, IMG_W/2-1), the next state is IDLE with busy=0. Otherwise the next state is RD0.
- Reads and writes are never asserted in the same cycle, because csel is shared.
- Throughput is 5 cycles per output word.
  - With the default parameters busy is high for exactly 1024*5 = 5120 cycles.
  - busy falls in the cycle after the final WR.
- start while busy is ignored and has no effect on counters.
- start in the same cycle that busy falls is not accepted. A new start must be issued in IDLE.
- Outside RDx/WR, crd=cwr=0 and csel=3'b000. Addresses and data hold their last values.

Test Plan:
- Ramp: L0[a]=a (a=0..4095), pulse start.
  - Every L1[k] = (2r)*64+2c+65. L1[0]=65, L1[1023]=4095.
  - busy high exactly 5120 cycles; 4096 reads; 1024 writes.
- Corner maximum: per window, place 20'h01000 in exactly one of the four positions (position cycles TL/TR/BL/BR by k mod 4); other three hold 20'h00010.
  - All L1 words = 20'h01000.
  - csel is 001 on every crd cycle and 011 on every cwr cycle.
- Signed compare: windows hold {20'hFFFFF, 20'h80000, 20'h00000, 20'hFFFF0}.
  - Output is 20'h00000.
  - An all-negative window {20'hFFFFF, 20'h80000, 20'hFFFF0, 20'hC0000} outputs 20'hFFFFF.
- start held high for 10 cycles, and re-pulsed at cycle 2000 of the operation.
  - Exactly one pass occurs; the address sequence is unchanged; busy is high for 5120 cycles.
- Reset mid-operation: assert reset low at cycle 1503 after start.
  - Next edge: busy=crd=cwr=0, csel=3'b000.
  - A new start then restarts from caddr_rd=0 and completes the full map correctly.
- Back-to-back: second start issued in the first IDLE cycle after busy falls.
  - The second pass reproduces identical L1 contents and timing.
